car_start_sequencer: RTL and testbench

//  Clocked controller downstream of the combinational car-safety logic. It consumes START_PERMIT,

---
 rtl/car_safety_pkg.sv | 31 +++
 rtl/car_start_sequencer_chime_cadence.sv | 89 ++++++++
 rtl/car_start_sequencer.sv | 126 ++++++++++++
 tb/tb_car_start_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_safety_pkg.sv
// ============================================================================
// Module : car_safety_pkg
// Brief  : Shared state/source encodings and default timing for the start sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package car_safety_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_IGN     = 3'd1,
        ST_CRANK   = 3'd2,
        ST_RUN     = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PRI1 = 2'd1,
        SRC_PRI2 = 2'd2
    } src_t;

    localparam int unsigned c_crank_cycles = 200;
    localparam int unsigned c_max_retries  = 3;
    localparam int unsigned c_beep_fast    = 8;
    localparam int unsigned c_beep_slow    = 32;

endpackage

`default_nettype wire

// File: rtl/car_start_sequencer_chime_cadence.sv
// ============================================================================
// Module : chime_cadence
// Brief  : Warning-to-chime cadence generator with per-priority acknowledge mutes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module chime_cadence
    import car_safety_pkg::*;
#(
    parameter int unsigned BEEP_FAST = c_beep_fast,
    parameter int unsigned BEEP_SLOW = c_beep_slow
) (
    input  logic clk,
    input  logic rst_n,
    input  logic warn_pri1,
    input  logic warn_pri2,
    input  logic ack,
    input  logic hold,
    output logic chime_out
);

    localparam int unsigned c_beep_max = (BEEP_SLOW > BEEP_FAST) ? BEEP_SLOW : BEEP_FAST;
    localparam int          c_cnt_w    = $clog2(c_beep_max + 1);
    localparam logic [c_cnt_w-1:0] c_fast = c_cnt_w'(BEEP_FAST);
    localparam logic [c_cnt_w-1:0] c_slow = c_cnt_w'(BEEP_SLOW);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    src_t               r_src, w_src, w_src_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt, w_half;
    logic               r_on, w_on_nxt;
    logic               r_chime;
    logic               r_mute1, r_mute2;

    always_comb begin
        w_src = SRC_NONE;
        if (warn_pri1 && !r_mute1) begin
            w_src = SRC_PRI1;
        end else if (warn_pri2 && !r_mute2) begin
            w_src = SRC_PRI2;
        end
    end

    // r_cnt counts cycles already spent in the current half-period (1..half)
    always_comb begin
        w_src_nxt = r_src;
        w_cnt_nxt = r_cnt;
        w_on_nxt  = r_on;
        w_half    = (w_src == SRC_PRI1) ? c_fast : c_slow;
        if (!hold) begin
            w_src_nxt = w_src;
            if (w_src == SRC_NONE) begin
                w_cnt_nxt = '0;
                w_on_nxt  = 1'b0;
            end else if (w_src != r_src) begin
                w_cnt_nxt = c_one;
                w_on_nxt  = 1'b1;
            end else if (r_cnt >= w_half) begin
                w_cnt_nxt = c_one;
                w_on_nxt  = !r_on;
            end else begin
                w_cnt_nxt = r_cnt + c_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src   <= SRC_NONE;
            r_cnt   <= '0;
            r_on    <= 1'b0;
            r_chime <= 1'b0;
            r_mute1 <= 1'b0;
            r_mute2 <= 1'b0;
        end else begin
            r_src   <= w_src_nxt;
            r_cnt   <= w_cnt_nxt;
            r_on    <= w_on_nxt;
            r_chime <= w_on_nxt && !hold;
            r_mute1 <= warn_pri1 && (r_mute1 || (ack && (w_src == SRC_PRI1)));
            r_mute2 <= warn_pri2 && (r_mute2 || (ack && (w_src == SRC_PRI2)));
        end
    end

    assign chime_out = r_chime;

endmodule

`default_nettype wire

// File: rtl/car_start_sequencer.sv
// ============================================================================
// Module : car_start_sequencer
// Brief  : Ignition/crank/run sequencer with retry lockout and warning chime.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module car_start_sequencer
    import car_safety_pkg::*;
#(
    parameter int unsigned CRANK_CYCLES = c_crank_cycles,
    parameter int unsigned MAX_RETRIES  = c_max_retries,
    parameter int unsigned BEEP_FAST    = c_beep_fast,
    parameter int unsigned BEEP_SLOW    = c_beep_slow
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    input  logic       start_btn,
    input  logic       start_permit,
    input  logic       warn_pri1,
    input  logic       warn_pri2,
    input  logic       eng_running,
    input  logic       ack,
    output logic       ign_on,
    output logic       crank,
    output logic       start_fault,
    output logic [2:0] state,
    output logic [1:0] retry_cnt,
    output logic       chime_out
);

    localparam int c_tmr_w = $clog2(CRANK_CYCLES + 1);
    localparam logic [c_tmr_w-1:0] c_tmr_load = c_tmr_w'(CRANK_CYCLES);
    localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);
    localparam logic [1:0]         c_max_rty  = 2'(MAX_RETRIES);

    state_t             r_state, w_state_nxt;
    logic [c_tmr_w-1:0] r_timer, w_timer_nxt;
    logic [1:0]         r_retry, w_retry_nxt, w_retry_inc;
    logic               r_btn_prev;
    logic               w_btn_rise;
    logic               w_hold;

    assign w_btn_rise  = start_btn && !r_btn_prev;
    assign w_retry_inc = (r_retry >= c_max_rty) ? c_max_rty : r_retry + 2'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_retry_nxt = r_retry;
        if (!key) begin
            w_state_nxt = ST_OFF;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                ST_OFF: w_state_nxt = ST_IGN;
                ST_IGN: begin
                    if (w_btn_rise && start_permit) begin
                        w_state_nxt = ST_CRANK;
                        w_timer_nxt = c_tmr_load;
                    end
                end
                ST_CRANK: begin
                    // A catch on the final crank cycle counts as success, not a timeout
                    if (eng_running) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = '0;
                    end else if (!start_permit) begin
                        w_state_nxt = ST_IGN;
                    end else if (r_timer <= c_tmr_one) begin
                        w_timer_nxt = '0;
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = (w_retry_inc == c_max_rty) ? ST_LOCKOUT : ST_IGN;
                    end else begin
                        w_timer_nxt = r_timer - c_tmr_one;
                    end
                end
                ST_RUN: begin
                    if (!eng_running) begin
                        w_state_nxt = ST_IGN;
                    end
                end
                ST_LOCKOUT: w_state_nxt = ST_LOCKOUT;
                default:    w_state_nxt = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_OFF;
            r_timer    <= '0;
            r_retry    <= '0;
            r_btn_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_retry    <= w_retry_nxt;
            r_btn_prev <= start_btn;
        end
    end

    assign w_hold      = (r_state == ST_CRANK);
    assign ign_on      = (r_state == ST_IGN) || (r_state == ST_CRANK) || (r_state == ST_RUN);
    assign crank       = (r_state == ST_CRANK);
    assign start_fault = (r_state == ST_LOCKOUT);
    assign state       = r_state;
    assign retry_cnt   = r_retry;

    chime_cadence #(
        .BEEP_FAST (BEEP_FAST),
        .BEEP_SLOW (BEEP_SLOW)
    ) u_chime (
        .clk       (clk),
        .rst_n     (rst_n),
        .warn_pri1 (warn_pri1),
        .warn_pri2 (warn_pri2),
        .ack       (ack),
        .hold      (w_hold),
        .chime_out (chime_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_car_start_sequencer.sv
// ============================================================================
// Module : tb_car_start_sequencer
// Brief  : Cycle-level scoreboard bench for car_start_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_car_start_sequencer;

    localparam int CRANK_CYCLES = 200;
    localparam int MAX_RETRIES  = 3;
    localparam int BEEP_FAST    = 8;
    localparam int BEEP_SLOW    = 32;

    logic       clk = 1'b0;
    logic       rst_n, key, start_btn, start_permit;
    logic       warn_pri1, warn_pri2, eng_running, ack;
    logic       ign_on, crank, start_fault, chime_out;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    always #5 clk = ~clk;

    car_start_sequencer #(
        .CRANK_CYCLES (CRANK_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .BEEP_FAST    (BEEP_FAST),
        .BEEP_SLOW    (BEEP_SLOW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key          (key),
        .start_btn    (start_btn),
        .start_permit (start_permit),
        .warn_pri1    (warn_pri1),
        .warn_pri2    (warn_pri2),
        .eng_running  (eng_running),
        .ack          (ack),
        .ign_on       (ign_on),
        .crank        (crank),
        .start_fault  (start_fault),
        .state        (state),
        .retry_cnt    (retry_cnt),
        .chime_out    (chime_out)
    );

    typedef struct {
        logic [2:0] st;
        logic       ign;
        logic       crk;
        logic       flt;
        logic [1:0] rt;
        logic       ch;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // reference model state
    int   m_state, m_retry, m_el, m_src, m_ph;
    logic m_prev, m_mute1, m_mute2, m_chime;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_step(output exp_t e);
        int   src, b;
        logic hold, btn_rise;
        if (!rst_n) begin
            m_state = 0; m_retry = 0; m_el = 0; m_src = 0; m_ph = 0;
            m_prev = 1'b0; m_mute1 = 1'b0; m_mute2 = 1'b0; m_chime = 1'b0;
        end else begin
            hold     = (m_state == 2);
            btn_rise = start_btn && !m_prev;
            src = (warn_pri1 && !m_mute1) ? 1 : ((warn_pri2 && !m_mute2) ? 2 : 0);
            b   = (src == 1) ? BEEP_FAST : BEEP_SLOW;
            if (hold) begin
                m_chime = 1'b0;
            end else begin
                if (src == 0 || src != m_src) m_ph = 0;
                else m_ph++;
                m_src   = src;
                m_chime = (src != 0) && (((m_ph / b) % 2) == 0);
            end
            m_mute1 = warn_pri1 && (m_mute1 || (ack && src == 1));
            m_mute2 = warn_pri2 && (m_mute2 || (ack && src == 2));
            m_prev  = start_btn;
            if (!key) begin
                m_state = 0;
                m_retry = 0;
            end else begin
                case (m_state)
                    0: m_state = 1;
                    1: if (btn_rise && start_permit) begin m_state = 2; m_el = 0; end
                    2: begin
                        if (eng_running) begin
                            m_state = 3; m_retry = 0;
                        end else if (!start_permit) begin
                            m_state = 1;
                        end else begin
                            m_el++;
                            if (m_el == CRANK_CYCLES) begin
                                m_retry++;
                                m_state = (m_retry == MAX_RETRIES) ? 4 : 1;
                            end
                        end
                    end
                    3: if (!eng_running) m_state = 1;
                    default: ;
                endcase
            end
        end
        e.st  = 3'(m_state);
        e.ign = (m_state >= 1) && (m_state <= 3);
        e.crk = (m_state == 2);
        e.flt = (m_state == 4);
        e.rt  = 2'(m_retry);
        e.ch  = m_chime;
    endtask

    task automatic cycle();
        exp_t e;
        model_step(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("state", state, e.st);
        chk("ign_on", ign_on, e.ign);
        chk("crank", crank, e.crk);
        chk("start_fault", start_fault, e.flt);
        chk("retry_cnt", retry_cnt, e.rt);
        chk("chime_out", chime_out, e.ch);
    endtask

    task automatic crank_attempt(input int exp_len, input int exp_retry);
        int len;
        len = 0;
        start_btn = 1'b1;
        cycle();
        start_btn = 1'b0;
        while (crank && len < 400) begin
            len++;
            cycle();
        end
        chk("crank_len", len, exp_len);
        chk("retry_after_attempt", retry_cnt, exp_retry);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; key = 1'b0; start_btn = 1'b0; start_permit = 1'b0;
        warn_pri1 = 1'b0; warn_pri2 = 1'b0; eng_running = 1'b0; ack = 1'b0;
        cycle();
        cycle();
        chk("rst_state", state, 0);
        chk("rst_ign", ign_on, 0);
        chk("rst_chime", chime_out, 0);

        // ignition, crank, catch on crank cycle 5
        rst_n = 1'b1; key = 1'b1; start_permit = 1'b1;
        cycle();
        chk("off_to_ign", state, 1);
        start_btn = 1'b1;
        cycle();
        start_btn = 1'b0;
        chk("ign_to_crank", state, 2);
        n = crank ? 1 : 0;
        repeat (4) begin
            cycle();
            if (crank) n++;
        end
        eng_running = 1'b1;
        cycle();
        if (crank) n++;
        chk("crank_len_run", n, 5);
        chk("run_state", state, 3);
        eng_running = 1'b0;
        cycle();
        chk("stall_to_ign", state, 1);

        // three timeouts into lockout
        crank_attempt(CRANK_CYCLES, 1);
        crank_attempt(CRANK_CYCLES, 2);
        crank_attempt(CRANK_CYCLES, 3);
        chk("lockout_state", state, 4);
        chk("lockout_fault", start_fault, 1);
        start_btn = 1'b1; cycle(); start_btn = 1'b0; cycle();
        chk("lockout_btn_ignored", state, 4);
        key = 1'b0;
        cycle();
        chk("key_off_state", state, 0);
        chk("key_off_retry", retry_cnt, 0);

        // permit gating and mid-crank abort
        key = 1'b1;
        cycle();
        start_permit = 1'b0;
        start_btn = 1'b1; cycle(); start_btn = 1'b0; cycle();
        chk("no_permit_stays_ign", state, 1);
        start_permit = 1'b1;
        cycle();
        chk("edge_not_queued", state, 1);
        crank_attempt(CRANK_CYCLES, 1);
        start_btn = 1'b1; cycle(); start_btn = 1'b0;
        repeat (10) cycle();
        start_permit = 1'b0;
        cycle();
        chk("abort_to_ign", state, 1);
        chk("abort_retry_kept", retry_cnt, 1);
        start_permit = 1'b1;

        // chime cadence and mutes
        warn_pri2 = 1'b1;
        cycle();
        n = chime_out ? 1 : 0;
        repeat (63) begin
            cycle();
            if (chime_out) n++;
        end
        chk("pri2_duty", n, BEEP_SLOW);
        warn_pri1 = 1'b1;
        cycle();
        chk("pri1_restart_on", chime_out, 1);
        n = 1;
        repeat (15) begin
            cycle();
            if (chime_out) n++;
        end
        chk("pri1_duty", n, BEEP_FAST);
        ack = 1'b1; cycle(); ack = 1'b0;
        repeat (70) cycle();
        ack = 1'b1; cycle(); ack = 1'b0;
        repeat (20) cycle();
        chk("all_muted_silent", chime_out, 0);
        warn_pri2 = 1'b0; cycle();
        warn_pri2 = 1'b1; cycle();
        chk("pri2_reassert_sounds", chime_out, 1);

        // reset while cranking with the chime sounding
        warn_pri1 = 1'b0; cycle();
        warn_pri1 = 1'b1; start_btn = 1'b1; cycle(); start_btn = 1'b0;
        chk("pre_rst_crank", crank, 1);
        chk("pre_rst_chime", chime_out, 1);
        rst_n = 1'b0;
        cycle();
        chk("mid_rst_crank", crank, 0);
        chk("mid_rst_ign", ign_on, 0);
        chk("mid_rst_chime", chime_out, 0);
        chk("mid_rst_state", state, 0);
        rst_n = 1'b1;

        // random soak against the model
        for (int i = 0; i < 600; i++) begin
            key          = ($urandom_range(39) != 0);
            start_permit = ($urandom_range(15) != 0);
            start_btn    = ($urandom_range(3) == 0);
            eng_running  = ($urandom_range(29) == 0) ? ~eng_running : eng_running;
            warn_pri1    = ($urandom_range(49) == 0) ? ~warn_pri1 : warn_pri1;
            warn_pri2    = ($urandom_range(39) == 0) ? ~warn_pri2 : warn_pri2;
            ack          = ($urandom_range(24) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
